task_8_stream_input: RTL and testbench

Parametrised store-and-forward ingress buffer for the task 8 datapath. It accepts one AXI-Stream-style packet into an internal buffer of `DEPTH` words, `DATA_W` bits each. It then replays the packet to the downstream core with a valid/ready handshake and a last marker. It adds downstream backpressure, packet-length reporting and oversize-packet handling, and replaces the fixed 8-bit ingress stage with its IP FIFO.

---
 rtl/task_8_stream_input.sv | 233 +++++++++++++++++++++++
 tb/tb_task_8_stream_input.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_8_stream_input.sv
// -----------------------------------------------------------------------------
// task_8_stream_input
//
// Store-and-forward ingress buffer. One upstream packet is loaded into an
// internal RAM of DEPTH words of DATA_W bits. The whole packet is then replayed
// downstream with a valid/ready handshake and a last marker.
//
// Build option:
//   TASK8_IN_OVERSIZE_DROP_EN  defined   -> an oversize packet is discarded whole
//                              undefined -> an oversize packet is truncated to
//                                           its first DEPTH words
//
// Parameters:
//   DATA_W  beat width in bits (1..64)
//   DEPTH   buffer capacity in words (power of two, >= 4)
//   LEN_W   width of the word counter and o_pkt_len
//
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_tdata_valid  upstream beat valid
//   i_tdata        upstream beat data
//   i_tdata_last   upstream final beat
//   o_tready       upstream beat accepted when high (registered)
//   o_data         downstream beat data (registered)
//   o_enb          downstream beat valid (registered)
//   o_last         downstream final beat, qualified by o_enb
//   i_ready        downstream accepts the current beat
//   o_busy         a packet is in progress
//   o_empty        no buffered words remain unsent
//   o_pkt_len      word count of the packet being sent, held until the next one
//   o_overflow     one-cycle pulse when an oversize packet is detected
// -----------------------------------------------------------------------------
module task_8_stream_input #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tdata_valid,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tdata_last,
    output logic              o_tready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_enb,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_empty,
    output logic [LEN_W-1:0]  o_pkt_len,
    output logic              o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DROP
    } state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  r_pkt_len;
    logic              r_tready;
    logic              r_enb;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              r_overflow;
`ifndef TASK8_IN_OVERSIZE_DROP_EN
    logic              r_ovf_seen;
`endif

    // Packet storage with a registered read port; r_ram_q is the prefetch
    // stage sitting one word ahead of the output register.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;
    logic              r_q_valid;
    logic              r_q_last;

    logic w_accept;
    logic w_full;
    logic w_wr_en;
    logic w_advance;
    logic w_rd_en;
    logic w_done;

    assign w_accept  = (r_state == S_LOAD) && r_tready && i_tdata_valid;
    assign w_full    = (r_count == LEN_W'(DEPTH));
    assign w_wr_en   = w_accept && !w_full;
    // The two-stage read pipeline moves only when the output slot is free
    // or being consumed, so a stall freezes both stages together.
    assign w_advance = !r_enb || i_ready;
    assign w_rd_en   = (r_state == S_SEND) && w_advance && (r_rd_cnt != r_pkt_len);
    assign w_done    = (r_state == S_SEND) && r_enb && i_ready && r_last;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_tdata;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_cnt   <= '0;
            r_pkt_len  <= '0;
            r_tready   <= 1'b0;
            r_enb      <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
            r_q_valid  <= 1'b0;
            r_q_last   <= 1'b0;
`ifndef TASK8_IN_OVERSIZE_DROP_EN
            r_ovf_seen <= 1'b0;
`endif
        end else begin
            r_overflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_count   <= '0;
                    r_rd_cnt  <= '0;
                    r_q_valid <= 1'b0;
                    r_q_last  <= 1'b0;
                    r_enb     <= 1'b0;
                    r_last    <= 1'b0;
                    r_tready  <= 1'b0;
`ifndef TASK8_IN_OVERSIZE_DROP_EN
                    r_ovf_seen <= 1'b0;
`endif
                    r_state   <= S_LOAD;
                end

                S_LOAD: begin
                    // o_tready lags entry into S_LOAD by one cycle.
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                            r_count  <= r_count + LEN_W'(1);
                        end
`ifdef TASK8_IN_OVERSIZE_DROP_EN
                        if (w_full) begin
                            r_overflow <= 1'b1;
                            r_tready   <= !i_tdata_last;
                            r_state    <= i_tdata_last ? S_IDLE : S_DROP;
                        end else if (i_tdata_last) begin
                            r_tready  <= 1'b0;
                            r_pkt_len <= r_count + LEN_W'(1);
                            r_state   <= S_SEND;
                        end
`else
                        if (w_full && !r_ovf_seen) begin
                            r_overflow <= 1'b1;
                            r_ovf_seen <= 1'b1;
                        end
                        if (i_tdata_last) begin
                            r_tready  <= 1'b0;
                            r_pkt_len <= w_full ? r_count : r_count + LEN_W'(1);
                            r_state   <= S_SEND;
                        end
`endif
                    end
                end

                S_SEND: begin
                    if (w_done) begin
                        r_enb   <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_advance) begin
                        r_enb <= r_q_valid;
                        if (r_q_valid) begin
                            r_data <= r_ram_q;
                            r_last <= r_q_last;
                        end else begin
                            r_last <= 1'b0;
                        end
                        if (w_rd_en) begin
                            r_q_valid <= 1'b1;
                            r_q_last  <= (r_rd_cnt == r_pkt_len - LEN_W'(1));
                            r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                            r_rd_cnt  <= r_rd_cnt + LEN_W'(1);
                        end else begin
                            r_q_valid <= 1'b0;
                        end
                    end
                end

                S_DROP: begin
                    if (r_tready && i_tdata_valid && i_tdata_last) begin
                        r_tready <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tready   = r_tready;
    assign o_data     = r_data;
    assign o_enb      = r_enb;
    assign o_last     = r_last;
    assign o_pkt_len  = r_pkt_len;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state == S_SEND) || (r_state == S_DROP) ||
                        ((r_state == S_LOAD) && (r_count != '0));
    // Words are only ever held in S_LOAD (not yet sent) or S_SEND (until
    // the final transfer, which leaves S_SEND in the same edge).
    assign o_empty    = !((r_state == S_SEND) ||
                          ((r_state == S_LOAD) && (r_count != '0)));

endmodule

// File: tb/tb_task_8_stream_input.sv
// -----------------------------------------------------------------------------
// Bench for task_8_stream_input. Two instances: the default build (DEPTH=256)
// and a DEPTH=4 build for oversize packets; one is observed at a time.
// -----------------------------------------------------------------------------
module tb_task_8_stream_input;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] tdata = 8'h00;
    bit         use4 = 1'b0;

    logic       tready_b, enb_b, last_b, busy_b, empty_b, ovf_b;
    logic [7:0] data_b;
    logic [8:0] len_b;
    logic       tready_s, enb_s, last_s, busy_s, empty_s, ovf_s;
    logic [7:0] data_s;
    logic [2:0] len_s;

    logic       w_tready, w_enb, w_last, w_busy, w_empty, w_overflow;
    logic [7:0] w_data;
    logic [8:0] w_pkt_len;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    beat_t      rx_q[$];
    beat_t      exp_q[$];
    int         end_q[$];
    logic [7:0] tx[$];
    int         acc_cyc[32];
    int         first_enb_cyc, last_xfer_cyc, tready_rise_cyc;
    int         ovf_cnt, ovf_cyc, exp_ovf, mdl_len;
    int         pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task_8_stream_input u_big (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata_valid(valid), .i_tdata(tdata),
        .i_tdata_last(last), .o_tready(tready_b), .o_data(data_b), .o_enb(enb_b),
        .o_last(last_b), .i_ready(ready), .o_busy(busy_b), .o_empty(empty_b),
        .o_pkt_len(len_b), .o_overflow(ovf_b)
    );

    task_8_stream_input #(.DATA_W(8), .DEPTH(4)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_tdata_valid(valid), .i_tdata(tdata),
        .i_tdata_last(last), .o_tready(tready_s), .o_data(data_s), .o_enb(enb_s),
        .o_last(last_s), .i_ready(ready), .o_busy(busy_s), .o_empty(empty_s),
        .o_pkt_len(len_s), .o_overflow(ovf_s)
    );

    always_comb begin
        if (use4) begin
            w_tready = tready_s; w_enb = enb_s; w_last = last_s; w_busy = busy_s;
            w_empty = empty_s; w_overflow = ovf_s; w_data = data_s;
            w_pkt_len = {6'd0, len_s};
        end else begin
            w_tready = tready_b; w_enb = enb_b; w_last = last_b; w_busy = busy_b;
            w_empty = empty_b; w_overflow = ovf_b; w_data = data_b;
            w_pkt_len = len_b;
        end
    end

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Downstream monitor: records transfers, checks stall stability.
    initial begin
        logic       p_enb, p_tready, p_stall, p_last;
        logic [7:0] p_data;
        beat_t      b;
        p_enb = 0; p_tready = 0; p_stall = 0; p_last = 0; p_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_enb = 0; p_tready = 0; p_stall = 0;
            end else begin
                if (p_stall) begin
                    chk("stall_enb", w_enb, 1);
                    chk("stall_data", w_data, p_data);
                    chk("stall_last", w_last, p_last);
                end
                if (w_enb && !p_enb) first_enb_cyc = cyc;
                if (w_tready && !p_tready) tready_rise_cyc = cyc;
                if (w_overflow) begin
                    ovf_cnt++;
                    ovf_cyc = cyc;
                end
                if (w_enb && ready) begin
                    b.d = w_data;
                    b.l = w_last;
                    rx_q.push_back(b);
                    last_xfer_cyc = cyc + 1;
                    if (w_last) end_q.push_back(cyc + 1);
                end
                p_stall  = w_enb && !ready;
                p_data   = w_data;
                p_last   = w_last;
                p_enb    = w_enb;
                p_tready = w_tready;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_tready"}, w_tready, 0);
        chk({tag, "_enb"}, w_enb, 0);
        chk({tag, "_last"}, w_last, 0);
        chk({tag, "_data"}, w_data, 0);
        chk({tag, "_pkt_len"}, w_pkt_len, 0);
        chk({tag, "_overflow"}, w_overflow, 0);
        chk({tag, "_busy"}, w_busy, 0);
        chk({tag, "_empty"}, w_empty, 1);
    endtask

    task automatic do_reset();
        rst_n = 0; valid = 0; last = 0; tdata = 0; ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rx_q.delete(); exp_q.delete(); end_q.delete();
        ovf_cnt = 0; exp_ovf = 0; mdl_len = 0;
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("tready_after_1", w_tready, 0);
        @(posedge clk); @(negedge clk);
        chk("tready_after_2", w_tready, 1);
        @(posedge clk); #1;
    endtask

    task automatic fill_seq(input int len, input logic [7:0] base);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back(base + 8'(i));
    endtask

    task automatic fill_rand(input int len);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference: what downstream must see for the packet in tx.
    task automatic model_pkt(input int len, input int depth);
        int    keep;
        beat_t b;
        keep = (len > depth) ? depth : len;
`ifdef TASK8_IN_OVERSIZE_DROP_EN
        if (len > depth) keep = 0;
`endif
        for (int i = 0; i < keep; i++) begin
            b.d = tx[i];
            b.l = (i == keep - 1);
            exp_q.push_back(b);
        end
        if (keep > 0) mdl_len = keep;
        if (len > depth) exp_ovf++;
    endtask

    task automatic send_pkt(input int len);
        bit acc;
        int w;
        for (int i = 0; i < len; i++) begin
            valid = 1; tdata = tx[i]; last = (i == len - 1);
            acc = 0; w = 0;
            while (!acc && w < 300) begin
                @(negedge clk);
                acc = w_tready;
                @(posedge clk); #1;
                w++;
            end
            chk("beat_accepted", acc, 1);
            acc_cyc[i] = cyc;
            if (!acc) break;
        end
        valid = 0; last = 0;
    endtask

    // mode 0: ready high; 1: fixed toggle pattern once o_enb is up; 2: random
    task automatic check_pkt(input int mode, input string tag);
        int w = 0;
        int k = 0;
        if (mode == 1) begin
            while (!w_enb && w < 50) begin
                @(posedge clk); #1; w++;
            end
        end
        w = 0;
        while (rx_q.size() < exp_q.size() && w < 400) begin
            if (mode == 0) ready = 1;
            else if (mode == 1) ready = (k < 7) ? (pat[k] != 0) : 1'b1;
            else ready = 1'($urandom_range(0, 1));
            k++;
            @(posedge clk); #1; w++;
        end
        ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                chk({tag, "_data"}, rx_q[i].d, exp_q[i].d);
                chk({tag, "_last"}, rx_q[i].l, exp_q[i].l);
            end
        end
        chk({tag, "_pkt_len"}, w_pkt_len, mdl_len);
        chk({tag, "_overflow_pulses"}, ovf_cnt, exp_ovf);
        rx_q.delete(); exp_q.delete();
        ovf_cnt = 0; exp_ovf = 0;
    endtask

    initial begin
        int lacc, acc2, len;

        // 5-beat packet, ready held high.
        use4 = 0;
        do_reset();
        fill_seq(5, 8'h11);
        model_pkt(5, 256);
        send_pkt(5);
        lacc = acc_cyc[4];
        chk("send_busy", w_busy, 1);
        chk("send_empty", w_empty, 0);
        check_pkt(0, "p5");
        chk("p5_first_enb", first_enb_cyc, lacc + 2);
        chk("p5_last_xfer", last_xfer_cyc, lacc + 2 + 5);
        chk("p5_tready_back", tready_rise_cyc, last_xfer_cyc + 2);
        chk("idle_busy", w_busy, 0);
        chk("idle_empty", w_empty, 1);

        // Single-word packet.
        fill_seq(1, 8'hA5);
        model_pkt(1, 256);
        send_pkt(1);
        check_pkt(0, "p1");

        // 4 words under a stalling consumer.
        fill_rand(4);
        model_pkt(4, 256);
        send_pkt(4);
        check_pkt(1, "stall");

        // Back-to-back packets with valid held high.
        end_q.delete();
        fill_rand(3);
        model_pkt(3, 256);
        send_pkt(3);
        fill_rand(3);
        model_pkt(3, 256);
        send_pkt(3);
        acc2 = acc_cyc[0];
        check_pkt(0, "b2b");
        chk("b2b_packets", end_q.size(), 2);
        // o_tready is back at M+2, so the first new beat lands on edge M+3.
        if (end_q.size() > 0) chk("b2b_accept_cycle", acc2, end_q[0] + 3);

        // Reset while the third word of an 8-word packet is presented.
        fill_rand(8);
        send_pkt(8);
        len = 0;
        while (rx_q.size() < 2 && len < 100) begin
            @(posedge clk); #1; len++;
        end
        chk("mid_enb", w_enb, 1);
        chk("mid_word2", w_data, tx[2]);
        rst_n = 0;
        #1;
        check_reset("async");
        chk("mid_rx_count", rx_q.size(), 2);
        do_reset();
        fill_rand(2);
        model_pkt(2, 256);
        send_pkt(2);
        check_pkt(0, "after_rst");

        // Random packets, random backpressure.
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 20);
            fill_rand(len);
            model_pkt(len, 256);
            send_pkt(len);
            check_pkt(2, "rnd");
        end

        // Oversize on the 4-word build.
        use4 = 1;
        do_reset();
        fill_seq(6, 8'h01);
        model_pkt(6, 4);
        send_pkt(6);
        lacc = acc_cyc[4];
        check_pkt(0, "oversize");
        chk("ovf_timing", ovf_cyc, lacc);
        chk("ovf_tready_back", w_tready, 1);

        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 7);
            fill_rand(len);
            model_pkt(len, 4);
            send_pkt(len);
            check_pkt(2, "rnd4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
